// File: rtl/cm_vga_timing_gen_pkg.sv
// Shared constants for the VGA timing generator: datapath widths, standard mode
// timings (640x480, 800x600, 1024x768) and a lookup helper returning a mode's porch set.
package cm_vga_timing_gen_pkg;

  // Datapath widths
  localparam int unsigned CounterWidth    = 11;
  localparam int unsigned DataWidth       = 12;
  localparam int unsigned BackPorchWidth  = 11;
  localparam int unsigned FrontPorchWidth = 11;

  typedef enum logic [1:0] {
    Mode640x480,
    Mode800x600,
    Mode1024x768
  } vga_mode_e;

  // 640x480 @ 60 Hz
  localparam int unsigned Mode640HTotal   = 800;
  localparam int unsigned Mode640HActive  = 640;
  localparam int unsigned Mode640HSyncGap = 16;
  localparam int unsigned Mode640HSyncLen = 96;
  localparam int unsigned Mode640VTotal   = 525;
  localparam int unsigned Mode640VActive  = 480;
  localparam int unsigned Mode640VSyncGap = 10;
  localparam int unsigned Mode640VSyncLen = 2;

  // 800x600 @ 60 Hz
  localparam int unsigned Mode800HTotal   = 1056;
  localparam int unsigned Mode800HActive  = 800;
  localparam int unsigned Mode800HSyncGap = 40;
  localparam int unsigned Mode800HSyncLen = 128;
  localparam int unsigned Mode800VTotal   = 628;
  localparam int unsigned Mode800VActive  = 600;
  localparam int unsigned Mode800VSyncGap = 1;
  localparam int unsigned Mode800VSyncLen = 4;

  // 1024x768 @ 60 Hz
  localparam int unsigned Mode1024HTotal   = 1344;
  localparam int unsigned Mode1024HActive  = 1024;
  localparam int unsigned Mode1024HSyncGap = 24;
  localparam int unsigned Mode1024HSyncLen = 136;
  localparam int unsigned Mode1024VTotal   = 806;
  localparam int unsigned Mode1024VActive  = 768;
  localparam int unsigned Mode1024VSyncGap = 3;
  localparam int unsigned Mode1024VSyncLen = 6;

  // Porch set as presented on the *_BackPorch (total) / *_FrontPorch (active) inputs
  typedef struct packed {
    logic [CounterWidth-1:0] h_tot;
    logic [CounterWidth-1:0] h_act;
    logic [CounterWidth-1:0] v_tot;
    logic [CounterWidth-1:0] v_act;
  } porch_set_t;

  function automatic porch_set_t mode_porch(input vga_mode_e mode);
    porch_set_t p;
    unique case (mode)
      Mode800x600: begin
        p.h_tot = CounterWidth'(Mode800HTotal);
        p.h_act = CounterWidth'(Mode800HActive);
        p.v_tot = CounterWidth'(Mode800VTotal);
        p.v_act = CounterWidth'(Mode800VActive);
      end
      Mode1024x768: begin
        p.h_tot = CounterWidth'(Mode1024HTotal);
        p.h_act = CounterWidth'(Mode1024HActive);
        p.v_tot = CounterWidth'(Mode1024VTotal);
        p.v_act = CounterWidth'(Mode1024VActive);
      end
      default: begin
        p.h_tot = CounterWidth'(Mode640HTotal);
        p.h_act = CounterWidth'(Mode640HActive);
        p.v_tot = CounterWidth'(Mode640VTotal);
        p.v_act = CounterWidth'(Mode640VActive);
      end
    endcase
    return p;
  endfunction

endpackage

// File: rtl/cm_vga_timing_gen_axis.sv
// cm_axis_counter: one raster axis (H or V). Counts when adv_i is high, wrapping to 0
// after tot_i-1, and decodes the active area and sync window around the count.
// Ports:
//   clk_i, rst_ni  clock, async active-low reset
//   adv_i          advance enable
//   tot_i, act_i   total length and active length of the axis
//   cnt_o          current count
//   last_o         count is tot_i-1 (wraps on next advance)
//   active_o       count < act_i
//   sync_o         count in [act_i+SyncGap, act_i+SyncGap+SyncLen)
module cm_axis_counter #(
  parameter int unsigned Width   = 11,
  parameter int unsigned SyncGap = 16,
  parameter int unsigned SyncLen = 96
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             adv_i,
  input  logic [Width-1:0] tot_i,
  input  logic [Width-1:0] act_i,
  output logic [Width-1:0] cnt_o,
  output logic             last_o,
  output logic             active_o,
  output logic             sync_o
);

  typedef logic [Width-1:0] cnt_t;
  typedef logic [Width:0]   ext_t;

  cnt_t cnt_q, cnt_d;
  ext_t sync_lo, sync_hi;

  assign last_o = (cnt_q == tot_i - cnt_t'(1));

  always_comb begin
    cnt_d = cnt_q;
    if (adv_i) begin
      cnt_d = last_o ? '0 : cnt_q + cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // One extra bit so act+gap+len near the top of the range cannot wrap
  assign sync_lo  = ext_t'(act_i) + ext_t'(SyncGap);
  assign sync_hi  = sync_lo + ext_t'(SyncLen);
  assign active_o = (cnt_q < act_i);
  assign sync_o   = (ext_t'(cnt_q) >= sync_lo) && (ext_t'(cnt_q) < sync_hi);
  assign cnt_o    = cnt_q;

endmodule

// File: rtl/cm_vga_timing_gen.sv
// VGA raster timing generator. Holds a shadow porch set that is only reloaded on the
// last pixel of a frame, drives pixel/line counters to the colour stage, and re-aligns
// the returned pixel with HS/VS/Frame_Start so all reach the pins 2 cycles after the
// counters.
// Ports:
//   clk, rst_n                    pixel clock, async active-low reset
//   H_BackPorch / V_BackPorch     requested H/V totals
//   H_FrontPorch / V_FrontPorch   requested H/V active sizes
//   Data_VGA                      pixel, one cycle after its counters
//   Counter_X/Y (+ _Valid)        current position and in-active flags
//   VGA_HS, VGA_VS, VGA_R/G/B     pin-aligned sync and blanked colour
//   Frame_Start                   pulse with pixel (0,0) at the pins
//   Cfg_Err                       pulse after a rejected porch capture
module cm_vga_timing_gen
  import cm_vga_timing_gen_pkg::*;
#(
  parameter int unsigned COUNTER_WIDTH    = CounterWidth,
  parameter int unsigned DATA_WIDTH       = DataWidth,
  parameter int unsigned BACKPORCH_WIDTH  = BackPorchWidth,
  parameter int unsigned FRONTPORCH_WIDTH = FrontPorchWidth,
  parameter int unsigned H_SYNC_GAP       = Mode640HSyncGap,
  parameter int unsigned H_SYNC_LEN       = Mode640HSyncLen,
  parameter int unsigned V_SYNC_GAP       = Mode640VSyncGap,
  parameter int unsigned V_SYNC_LEN       = Mode640VSyncLen,
  parameter logic        SYNC_ACTIVE      = 1'b0,
  parameter int unsigned H_TOTAL_RST      = Mode640HTotal,
  parameter int unsigned H_ACT_RST        = Mode640HActive,
  parameter int unsigned V_TOTAL_RST      = Mode640VTotal,
  parameter int unsigned V_ACT_RST        = Mode640VActive
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [BACKPORCH_WIDTH-1:0]  H_BackPorch,
  input  logic [FRONTPORCH_WIDTH-1:0] H_FrontPorch,
  input  logic [BACKPORCH_WIDTH-1:0]  V_BackPorch,
  input  logic [FRONTPORCH_WIDTH-1:0] V_FrontPorch,
  input  logic [DATA_WIDTH-1:0]       Data_VGA,
  output logic [COUNTER_WIDTH-1:0]    Counter_X,
  output logic [COUNTER_WIDTH-1:0]    Counter_Y,
  output logic                        Counter_X_Valid,
  output logic                        Counter_Y_Valid,
  output logic                        VGA_HS,
  output logic                        VGA_VS,
  output logic [DATA_WIDTH/3-1:0]     VGA_R,
  output logic [DATA_WIDTH/3-1:0]     VGA_G,
  output logic [DATA_WIDTH/3-1:0]     VGA_B,
  output logic                        Frame_Start,
  output logic                        Cfg_Err
);

  localparam int unsigned CompW = DATA_WIDTH / 3;
  localparam int unsigned RgbW  = 3 * CompW;

  typedef logic [COUNTER_WIDTH-1:0] cnt_t;
  typedef logic [COUNTER_WIDTH:0]   ext_t;

  // Shadow porch set in use
  cnt_t h_tot_q, h_tot_d, h_act_q, h_act_d;
  cnt_t v_tot_q, v_tot_d, v_act_q, v_act_d;
  logic cfg_err_q, cfg_err_d;

  cnt_t h_cnt, v_cnt;
  logic h_last, v_last, h_active, v_active, h_sync, v_sync;
  logic frame_end, cfg_ok;

  cm_axis_counter #(
    .Width  (COUNTER_WIDTH),
    .SyncGap(H_SYNC_GAP),
    .SyncLen(H_SYNC_LEN)
  ) u_h_axis (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .adv_i   (1'b1),
    .tot_i   (h_tot_q),
    .act_i   (h_act_q),
    .cnt_o   (h_cnt),
    .last_o  (h_last),
    .active_o(h_active),
    .sync_o  (h_sync)
  );

  cm_axis_counter #(
    .Width  (COUNTER_WIDTH),
    .SyncGap(V_SYNC_GAP),
    .SyncLen(V_SYNC_LEN)
  ) u_v_axis (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .adv_i   (h_last),
    .tot_i   (v_tot_q),
    .act_i   (v_act_q),
    .cnt_o   (v_cnt),
    .last_o  (v_last),
    .active_o(v_active),
    .sync_o  (v_sync)
  );

  assign frame_end = h_last && v_last;

  // Sync window must fit inside the total; evaluated one bit wider than the counters
  always_comb begin
    cfg_ok = (H_FrontPorch != '0) && (V_FrontPorch != '0)
          && (ext_t'(H_FrontPorch) + ext_t'(H_SYNC_GAP) + ext_t'(H_SYNC_LEN)
              <= ext_t'(H_BackPorch))
          && (ext_t'(V_FrontPorch) + ext_t'(V_SYNC_GAP) + ext_t'(V_SYNC_LEN)
              <= ext_t'(V_BackPorch));
  end

  always_comb begin
    h_tot_d   = h_tot_q;
    h_act_d   = h_act_q;
    v_tot_d   = v_tot_q;
    v_act_d   = v_act_q;
    cfg_err_d = 1'b0;
    if (frame_end) begin
      if (cfg_ok) begin
        h_tot_d = cnt_t'(H_BackPorch);
        h_act_d = cnt_t'(H_FrontPorch);
        v_tot_d = cnt_t'(V_BackPorch);
        v_act_d = cnt_t'(V_FrontPorch);
      end else begin
        cfg_err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_tot_q   <= cnt_t'(H_TOTAL_RST);
      h_act_q   <= cnt_t'(H_ACT_RST);
      v_tot_q   <= cnt_t'(V_TOTAL_RST);
      v_act_q   <= cnt_t'(V_ACT_RST);
      cfg_err_q <= 1'b0;
    end else begin
      h_tot_q   <= h_tot_d;
      h_act_q   <= h_act_d;
      v_tot_q   <= v_tot_d;
      v_act_q   <= v_act_d;
      cfg_err_q <= cfg_err_d;
    end
  end

  // Stage 0: registered counter state, presented to the colour stage
  cnt_t cx_q, cy_q;
  logic xv_q, yv_q, hs0_q, vs0_q, fs0_q;
  // Stage 1: waits out the colour stage's one-cycle latency
  logic act1_q, hs1_q, vs1_q, fs1_q;
  // Output stage
  logic [RgbW-1:0] rgb_q;
  logic            hs_q, vs_q, fs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cx_q   <= '0;
      cy_q   <= '0;
      xv_q   <= 1'b0;
      yv_q   <= 1'b0;
      hs0_q  <= 1'b0;
      vs0_q  <= 1'b0;
      fs0_q  <= 1'b0;
      act1_q <= 1'b0;
      hs1_q  <= 1'b0;
      vs1_q  <= 1'b0;
      fs1_q  <= 1'b0;
      rgb_q  <= '0;
      hs_q   <= ~SYNC_ACTIVE;
      vs_q   <= ~SYNC_ACTIVE;
      fs_q   <= 1'b0;
    end else begin
      cx_q   <= h_cnt;
      cy_q   <= v_cnt;
      xv_q   <= h_active;
      yv_q   <= v_active;
      hs0_q  <= h_sync;
      vs0_q  <= v_sync;
      fs0_q  <= (h_cnt == '0) && (v_cnt == '0);
      act1_q <= xv_q && yv_q;
      hs1_q  <= hs0_q;
      vs1_q  <= vs0_q;
      fs1_q  <= fs0_q;
      rgb_q  <= act1_q ? Data_VGA[RgbW-1:0] : '0;
      hs_q   <= hs1_q ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      vs_q   <= vs1_q ? SYNC_ACTIVE : ~SYNC_ACTIVE;
      fs_q   <= fs1_q;
    end
  end

  assign Counter_X       = cx_q;
  assign Counter_Y       = cy_q;
  assign Counter_X_Valid = xv_q;
  assign Counter_Y_Valid = yv_q;
  assign VGA_R           = rgb_q[RgbW-1 -: CompW];
  assign VGA_G           = rgb_q[RgbW-CompW-1 -: CompW];
  assign VGA_B           = rgb_q[CompW-1:0];
  assign VGA_HS          = hs_q;
  assign VGA_VS          = vs_q;
  assign Frame_Start     = fs_q;
  assign Cfg_Err         = cfg_err_q;

endmodule

// File: tb/tb_cm_vga_timing_gen.sv
// Bench for cm_vga_timing_gen on a tiny raster (H 10/6, V 7/4, gaps 1, lens 2).
// The reference model tracks the raster as a linear pixel index within the frame and
// derives positions, windows and pipeline delays arithmetically; expectations are
// queued on each clock edge and a monitor compares them on the falling edge.
module tb_cm_vga_timing_gen;

  localparam int HGap = 1;
  localparam int HLen = 2;
  localparam int VGap = 1;
  localparam int VLen = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] h_bp = 11'd10, h_fp = 11'd6, v_bp = 11'd7, v_fp = 11'd4;
  logic [11:0] data = '0;
  logic [10:0] cnt_x, cnt_y;
  logic        x_valid, y_valid, vga_hs, vga_vs, frame_start, cfg_err;
  logic [3:0]  vga_r, vga_g, vga_b;

  cm_vga_timing_gen #(
    .H_SYNC_GAP (HGap),
    .H_SYNC_LEN (HLen),
    .V_SYNC_GAP (VGap),
    .V_SYNC_LEN (VLen),
    .SYNC_ACTIVE(1'b0),
    .H_TOTAL_RST(10),
    .H_ACT_RST  (6),
    .V_TOTAL_RST(7),
    .V_ACT_RST  (4)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .H_BackPorch    (h_bp),
    .H_FrontPorch   (h_fp),
    .V_BackPorch    (v_bp),
    .V_FrontPorch   (v_fp),
    .Data_VGA       (data),
    .Counter_X      (cnt_x),
    .Counter_Y      (cnt_y),
    .Counter_X_Valid(x_valid),
    .Counter_Y_Valid(y_valid),
    .VGA_HS         (vga_hs),
    .VGA_VS         (vga_vs),
    .VGA_R          (vga_r),
    .VGA_G          (vga_g),
    .VGA_B          (vga_b),
    .Frame_Start    (frame_start),
    .Cfg_Err        (cfg_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         x;
    int         y;
    bit         xv;
    bit         yv;
    bit         err;
    bit [11:0]  rgb;
    bit         hs;
    bit         vs;
    bit         fs;
  } exp_t;

  typedef struct {
    bit act;
    bit hs;
    bit vs;
    bit fs;
  } pix_t;

  exp_t exp_q[$];
  pix_t hist[$];
  int   ht = 10, ha = 6, vt = 7, va = 4;
  int   pos = 0;
  int   shown_x = -1, shown_y = -1;
  int   n_cmp = 0, n_bad = 0;
  bit   const_data = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic bit legal(input int hf, input int hb, input int vf, input int vb);
    return (hf != 0) && (vf != 0) && (hf + HGap + HLen <= hb) && (vf + VGap + VLen <= vb);
  endfunction

  function automatic pix_t idle_pix();
    pix_t p;
    p.act = 1'b0;
    p.hs  = 1'b0;
    p.vs  = 1'b0;
    p.fs  = 1'b0;
    return p;
  endfunction

  // Reference model: one step per rising edge, same input samples as the DUT
  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      ht = 10; ha = 6; vt = 7; va = 4; pos = 0;
      exp_q.delete();
      hist.delete();
      hist.push_back(idle_pix());
      hist.push_back(idle_pix());
      shown_x = -1;
      shown_y = -1;
    end else begin
      exp_t e;
      pix_t p, old;
      int x, y;
      x = pos % ht;
      y = pos / ht;
      e.x  = x;
      e.y  = y;
      e.xv = (x < ha);
      e.yv = (y < va);
      p.act = e.xv && e.yv;
      p.hs  = (x >= ha + HGap) && (x < ha + HGap + HLen);
      p.vs  = (y >= va + VGap) && (y < va + VGap + VLen);
      p.fs  = (pos == 0);
      // Pins now show the pixel whose counters appeared two edges ago
      old = hist.pop_front();
      hist.push_back(p);
      e.rgb = old.act ? data : 12'h000;
      e.hs  = !old.hs;
      e.vs  = !old.vs;
      e.fs  = old.fs;
      e.err = 1'b0;
      if (pos == ht * vt - 1) begin
        if (legal(int'(h_fp), int'(h_bp), int'(v_fp), int'(v_bp))) begin
          ht = int'(h_bp); ha = int'(h_fp); vt = int'(v_bp); va = int'(v_fp);
        end else begin
          e.err = 1'b1;
        end
        pos = 0;
      end else begin
        pos++;
      end
      shown_x = x;
      shown_y = y;
      exp_q.push_back(e);
    end
  end

  // Monitor
  initial forever begin
    @(negedge clk);
    if (rst_n && exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("Counter_X", 32'(cnt_x), 32'(e.x));
      chk("Counter_Y", 32'(cnt_y), 32'(e.y));
      chk("X_Valid", 32'(x_valid), 32'(e.xv));
      chk("Y_Valid", 32'(y_valid), 32'(e.yv));
      chk("RGB", 32'({vga_r, vga_g, vga_b}), 32'(e.rgb));
      chk("VGA_HS", 32'(vga_hs), 32'(e.hs));
      chk("VGA_VS", 32'(vga_vs), 32'(e.vs));
      chk("Frame_Start", 32'(frame_start), 32'(e.fs));
      chk("Cfg_Err", 32'(cfg_err), 32'(e.err));
    end
  end

  // Pixel source
  initial forever begin
    @(negedge clk);
    data = const_data ? 12'hABC : 12'($urandom);
  end

  task automatic run(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_pos(input int target);
    int i;
    i = 0;
    while (pos != target && i < 400) begin
      @(negedge clk);
      i++;
    end
    if (pos != target) begin
      n_cmp++;
      n_bad++;
      $display("FAIL wait_pos: raster never reached index %0d", target);
    end
  endtask

  task automatic check_reset(input string tag);
    chk({tag, " Counter_X"}, 32'(cnt_x), 32'd0);
    chk({tag, " Counter_Y"}, 32'(cnt_y), 32'd0);
    chk({tag, " X_Valid"}, 32'(x_valid), 32'd0);
    chk({tag, " Y_Valid"}, 32'(y_valid), 32'd0);
    chk({tag, " RGB"}, 32'({vga_r, vga_g, vga_b}), 32'd0);
    chk({tag, " VGA_HS"}, 32'(vga_hs), 32'd1);
    chk({tag, " VGA_VS"}, 32'(vga_vs), 32'd1);
    chk({tag, " Frame_Start"}, 32'(frame_start), 32'd0);
    chk({tag, " Cfg_Err"}, 32'(cfg_err), 32'd0);
  endtask

  task automatic measure_fs_period(input int req);
    int i, n;
    i = 0;
    while (frame_start !== 1'b1 && i < 300) begin
      @(negedge clk);
      i++;
    end
    if (frame_start !== 1'b1) begin
      n_cmp++;
      n_bad++;
      $display("FAIL fs_period: no Frame_Start seen, required period %0d", req);
    end else begin
      n = 0;
      do begin
        @(negedge clk);
        n++;
      end while (frame_start !== 1'b1 && n < 300);
      chk("fs_period", 32'(n), 32'(req));
    end
  endtask

  task automatic count_err_pulses(input int cycles, input int req);
    int n;
    n = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (cfg_err === 1'b1) n++;
    end
    chk("cfg_err_pulses", 32'(n), 32'(req));
  endtask

  initial begin
    int i;
    rst_n = 1'b0;
    run(3);
    check_reset("in_reset");
    #2 rst_n = 1'b1;

    // Default timing with random pixels, then a constant colour
    run(140);
    measure_fs_period(70);
    const_data = 1'b1;
    run(70);
    const_data = 1'b0;

    // Mode switch mid-frame: current frame keeps 10/6, next is 12/8
    wait_pos(20);
    h_bp = 11'd12;
    h_fp = 11'd8;
    run(170);
    measure_fs_period(84);

    // Illegal value that comes and goes inside a frame is never captured
    wait_pos(10);
    h_fp = 11'd11;
    run(20);
    h_fp = 11'd8;
    run(100);

    // Back to 10/6
    wait_pos(30);
    h_bp = 11'd10;
    h_fp = 11'd6;
    run(150);

    // Rejected capture: active 9 does not leave room for the sync window in total 10
    wait_pos(30);
    h_fp = 11'd9;
    count_err_pulses(70, 1);
    wait_pos(30);
    h_fp = 11'd6;
    measure_fs_period(70);

    // Random porch sets, some illegal
    for (int k = 0; k < 6; k++) begin
      int hb, hf, vb, vf;
      hb = $urandom_range(14, 8);
      hf = $urandom_range(hb - 1, 0);
      vb = $urandom_range(9, 7);
      vf = $urandom_range(vb - 2, 0);
      wait_pos($urandom_range(30, 5));
      h_bp = 11'(hb);
      h_fp = 11'(hf);
      v_bp = 11'(vb);
      v_fp = 11'(vf);
      run(130);
    end
    wait_pos(5);
    h_bp = 11'd10;
    h_fp = 11'd6;
    v_bp = 11'd7;
    v_fp = 11'd4;
    run(200);
    measure_fs_period(70);

    // Asynchronous reset at (4,2)
    i = 0;
    while (!(shown_x == 4 && shown_y == 2) && i < 300) begin
      @(negedge clk);
      i++;
    end
    chk("pre_reset_x", 32'(cnt_x), 32'd4);
    chk("pre_reset_y", 32'(cnt_y), 32'd2);
    #2 rst_n = 1'b0;
    #1 check_reset("async_reset");
    run(2);
    check_reset("held_reset");
    #2 rst_n = 1'b1;
    run(150);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/cm_vga_timing_gen.md
# cm_vga_timing_gen

VGA raster timing generator that sits directly upstream of the color-assignment stage. It turns the porch values produced by that stage into pixel and line counters, drives `Counter_X`/`Counter_Y` with their valid flags back into it, and takes the resulting `Data_VGA` pixel. It then emits pin-aligned `VGA_HS`, `VGA_VS` and split R/G/B, blanked outside the active region. Porch changes apply only at frame boundaries so the raster never tears.

## Interface
Parameters:
- COUNTER_WIDTH, 11, width of the X/Y counters.
- DATA_WIDTH, 12, pixel width, split evenly into R, G and B (MSB field is R).
- BACKPORCH_WIDTH, 11, width of the `*_BackPorch` inputs.
- FRONTPORCH_WIDTH, 11, width of the `*_FrontPorch` inputs.
- H_SYNC_GAP, 16, pixels from end of active area to the start of HS.
- H_SYNC_LEN, 96, HS pulse width in pixels.
- V_SYNC_GAP, 10, lines from end of active area to the start of VS.
- V_SYNC_LEN, 2, VS pulse width in lines.
- SYNC_ACTIVE, 1'b0, active level of HS and VS.
- H_TOTAL_RST, 800, reset value of the H total.
- H_ACT_RST, 640, reset value of the H active width.
- V_TOTAL_RST, 525, reset value of the V total.
- V_ACT_RST, 480, reset value of the V active height.

Ports:
- clk  in  1  pixel clock; the design uses one clock.
- rst_n  in  1  reset; asynchronous assertion, active-low.
- H_BackPorch  in  BACKPORCH_WIDTH  horizontal total (pixels per line).
- H_FrontPorch  in  FRONTPORCH_WIDTH  horizontal active width.
- V_BackPorch  in  BACKPORCH_WIDTH  vertical total (lines per frame).
- V_FrontPorch  in  FRONTPORCH_WIDTH  vertical active height.
- Data_VGA  in  DATA_WIDTH  pixel from the color stage; arrives one cycle after the matching counters.
- Counter_X, Counter_Y  out  COUNTER_WIDTH  current pixel position.
- Counter_X_Valid, Counter_Y_Valid  out  1  current X (respectively Y) is inside the active area.
- VGA_HS, VGA_VS  out  1  sync outputs.
- VGA_R, VGA_G, VGA_B  out  DATA_WIDTH/3  color outputs.
- Frame_Start  out  1  one-cycle pulse aligned with pixel (0,0) at the pins.
- Cfg_Err  out  1  one-cycle pulse when a porch capture is rejected.

## Operation
- Shadow registers hold the porch set in use: `h_tot`, `h_act`, `v_tot`, `v_act`.
  - Reset loads them from the *_RST parameters.
  - Capture happens only on the last cycle of a frame (`h_cnt==h_tot-1` and `v_cnt==v_tot-1`).
  - A captured set takes effect at pixel (0,0) of the next frame.
- A capture is rejected, old set kept and `Cfg_Err` pulsed, when any of the following holds:
  - `H_FrontPorch==0` or `V_FrontPorch==0`;
  - `H_FrontPorch+H_SYNC_GAP+H_SYNC_LEN > H_BackPorch`;
  - `V_FrontPorch+V_SYNC_GAP+V_SYNC_LEN > V_BackPorch`.
  - All sums are evaluated at COUNTER_WIDTH+1 bits.
- The horizontal counter `h_cnt` runs 0..h_tot-1 and wraps. The vertical counter `v_cnt` increments on the h wrap and itself wraps after v_tot-1.
- Stage 0 is a registered copy of the counter state:
  - `Counter_X=h_cnt`, `Counter_Y=v_cnt`;
  - `Counter_X_Valid=(h_cnt<h_act)`, `Counter_Y_Valid=(v_cnt<v_act)`;
  - `hs_raw`: asserted when `h_cnt` is in [h_act+H_SYNC_GAP, +H_SYNC_LEN);
  - `vs_raw`: asserted when `v_cnt` is in [v_act+V_SYNC_GAP, +V_SYNC_LEN), held for whole lines.
- Stage 1 delays `active=X_Valid&&Y_Valid`, `hs_raw`, `vs_raw` and the frame-start flag by one cycle.
- Output stage (registered):
  - `{VGA_R,VGA_G,VGA_B} = active_d ? Data_VGA : 0`;
  - HS and VS are driven at SYNC_ACTIVE while asserted and at ~SYNC_ACTIVE otherwise.

## Timing
- Counter outputs for pixel P appear at cycle t. `Data_VGA` for P is sampled at t+1. Pins reflect P at t+2. Total latency from counters to pins is 2 cycles for color, HS, VS and `Frame_Start` alike.
- Reset values:
  - `Counter_X/Y` = 0 and both valids = 0;
  - VGA_R/G/B = 0;
  - HS and VS = ~SYNC_ACTIVE;
  - `Frame_Start` and `Cfg_Err` = 0.
- First edge after reset release: outputs show (0,0) with both valids = 1.
- Reset mid-frame: all state returns to the reset values immediately (asynchronously), the shadow set returns to the *_RST values, and no partial pulse survives.
- Porch inputs that change mid-frame have no effect until the frame-end capture. A change that comes and goes within a frame is never seen.
- On the frame-end cycle, an h wrap and a v wrap coincide with the capture. The next cycle starts at (0,0) under the new totals.
- `Cfg_Err` is asserted on the cycle after the rejected capture.

## Structure
- The shared parameter package holds:
  - the per-mode totals, active sizes and sync gap/len constants (640x480, 800x600, 1024x768), alongside the existing mode and porch constants;
  - the width parameters.
- One sub-module, `cm_axis_counter`, instantiated for H and for V:
  - counts with an advance enable and wraps at a programmable total;
  - produces `active` and `sync` compares.

## Test plan
- Reset values: small timing (H 10/6, V 6/4, all gaps 1, all lens 2; SYNC_ACTIVE=0) -> `Counter_X` cycles 0..9; X_Valid is high for X 0..5; HS is low at the pins for X=7,8 (2-cycle shifted); VS is low for lines 5..6 clamped to total, so use V total 7.
- Data pass-through: `Data_VGA=12'hABC` constant -> R=A, G=B, B=C inside the active area and 0 in blanking; the first colored pixel appears 2 cycles after (0,0) valid.
- Mode switch: porch inputs changed to H 12/8 mid-frame -> the current frame stays 10/6; the next frame line length is 12 exactly from (0,0).
- Illegal config: H_FrontPorch=9 with total 10 -> `Cfg_Err` pulses once at the frame end and the timing stays 10/6.
- Async reset asserted at X=4, Y=2 -> outputs return to reset values without waiting for a clock edge; after release, X restarts at 0.
- `Frame_Start` pulses exactly once per frame (every 70 cycles at 10x7), coincident with pixel (0,0) color at the pins.
